i2c_read: RTL and testbench

//   Receive-side counterpart of the I2C bit/byte writer, usable in both master and slave.

---
 rtl/i2c_read.sv | 108 ++++++++++
 tb/tb_i2c_read.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_read.sv
// i2c_read: receive side of the I2C bit/byte engine.
// Samples SDA on SCL rising edges (MSB first), reports start/stop conditions,
// flags conditions that land inside a byte, and marks completion on the SCL
// falling edge that closes the last bit. This block never drives SDA.
module i2c_read #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  is_byte,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rd_ld,
    output logic                  get_start,
    output logic                  get_stop,
    output logic                  bus_err,
    output logic                  rd_finish
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    logic                  scl_last_q, sda_last_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  abort_q, abort_d;
    logic                  bus_err_q, bus_err_d;
    logic                  finish_q, finish_d;

    logic scl_rise, scl_fall, cond_seen, last_bit;

    // Edge and condition detection against the previous-cycle line levels;
    // requiring scl_last high keeps an SDA change on the SCL-rise cycle
    // from being mistaken for a start/stop.
    always_comb begin
        scl_rise  = rd_en & ~scl_last_q & scl_i;
        scl_fall  = rd_en & scl_last_q & ~scl_i;
        get_start = rd_en & scl_i & scl_last_q & sda_last_q & ~sda_i;
        get_stop  = rd_en & scl_i & scl_last_q & ~sda_last_q & sda_i;
        cond_seen = get_start | get_stop;
        rd_ld     = scl_rise;
        last_bit  = is_byte ? (bit_cnt_q == CNT_MAX) : (bit_cnt_q == '0);
    end

    // Next-state: shift on rise (until finished), count on fall, track
    // legal (bit 0) versus illegal (mid-byte) conditions; rd_en low clears.
    always_comb begin
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = abort_q;
        bus_err_d = bus_err_q;
        finish_d  = finish_q;
        if (scl_rise && !finish_q) begin
            data_d = {data_q[DATA_WIDTH-2:0], sda_i};
        end
        if (!rd_en) begin
            bit_cnt_d = '0;
            abort_d   = 1'b0;
            bus_err_d = 1'b0;
            finish_d  = 1'b0;
        end else begin
            if (scl_fall) begin
                if (is_byte) begin
                    bit_cnt_d = (bit_cnt_q == CNT_MAX) ? '0 : bit_cnt_q + 1'b1;
                end else begin
                    bit_cnt_d = '0;
                end
                if (!abort_q && last_bit) begin
                    finish_d = 1'b1;
                end
            end
            if (cond_seen) begin
                abort_d = 1'b1;
                if (is_byte && bit_cnt_q != '0) begin
                    bus_err_d = 1'b1;
                end
            end
        end
    end

    // State registers; line trackers idle high so a released bus shows no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_last_q <= 1'b1;
            sda_last_q <= 1'b1;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            abort_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            scl_last_q <= scl_i;
            sda_last_q <= sda_i;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            abort_q    <= abort_d;
            bus_err_q  <= bus_err_d;
            finish_q   <= finish_d;
        end
    end

    assign data_o    = data_q;
    assign bus_err   = bus_err_q;
    assign rd_finish = finish_q;

endmodule

// File: tb/tb_i2c_read.sv
// Scoreboard bench for i2c_read: stimulus pushes expected events/snapshots,
// a negedge monitor pops and compares them when the DUT produces them.
module tb_i2c_read;

    localparam int KSNAP  = 0;
    localparam int KFIN   = 1;
    localparam int KSTART = 2;
    localparam int KSTOP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic       is_byte = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic [7:0] data_o;
    logic       rd_ld, get_start, get_stop, bus_err, rd_finish;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       err;
        logic       fin;
        int         ld;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ld_cnt   = 0;
    logic fin_prev = 1'b0;
    logic snap_req = 1'b0;

    i2c_read #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .is_byte  (is_byte),
        .scl_i    (scl),
        .sda_i    (sda),
        .data_o   (data_o),
        .rd_ld    (rd_ld),
        .get_start(get_start),
        .get_stop (get_stop),
        .bus_err  (bus_err),
        .rd_finish(rd_finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic handle(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
            return;
        end
        e = q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            KFIN: begin
                check("finish_data", int'(data_o), int'(e.data));
                check("finish_ld_count", ld_cnt, e.ld);
                check("finish_bus_err", int'(bus_err), 0);
                $display("txn finish data=0x%02h ld=%0d", data_o, ld_cnt);
            end
            KSNAP: begin
                check("snap_data", int'(data_o), int'(e.data));
                check("snap_bus_err", int'(bus_err), int'(e.err));
                check("snap_rd_finish", int'(rd_finish), int'(e.fin));
                $display("txn snap data=0x%02h err=%0b fin=%0b", data_o, bus_err, rd_finish);
            end
            KSTART: $display("txn start condition");
            default: $display("txn stop condition");
        endcase
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || !rd_en) ld_cnt = 0;
            else if (rd_ld) ld_cnt++;
            if (rd_finish && !fin_prev) handle(KFIN);
            if (get_start) handle(KSTART);
            if (get_stop) handle(KSTOP);
            if (snap_req) handle(KSNAP);
            fin_prev = rd_finish;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sda = v[i];
            wait_clk(2);
            scl = 1'b1;
            wait_clk(4);
            scl = 1'b0;
            wait_clk(2);
        end
    endtask

    task automatic push_ev(input int kind);
        exp_t e;
        e.kind = kind; e.data = 8'h00; e.err = 1'b0; e.fin = 1'b0; e.ld = 0;
        q.push_back(e);
    endtask

    task automatic push_fin(input logic [7:0] d, input int ld);
        exp_t e;
        e.kind = KFIN; e.data = d; e.err = 1'b0; e.fin = 1'b1; e.ld = ld;
        q.push_back(e);
    endtask

    task automatic snap(input logic [7:0] d, input logic err, input logic fin);
        exp_t e;
        e.kind = KSNAP; e.data = d; e.err = err; e.fin = fin; e.ld = 0;
        q.push_back(e);
        snap_req = 1'b1;
        @(negedge clk);
        #1;
        snap_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        wait_clk(2);
        snap(8'h00, 1'b0, 1'b0);
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(2);
        scl = 1'b0;
        wait_clk(2);

        // Byte mode 0xA5
        is_byte = 1'b1;
        rd_en = 1'b1;
        push_fin(8'hA5, 8);
        send_bits(8'hA5, 8);
        snap(8'hA5, 1'b0, 1'b1);
        rd_en = 1'b0;
        wait_clk(2);
        snap(8'hA5, 1'b0, 1'b0);

        // Bit mode ACK, then a further pulse must not shift
        is_byte = 1'b0;
        rd_en = 1'b1;
        push_fin(8'h4A, 1);
        send_bits(8'h00, 1);
        snap(8'h4A, 1'b0, 1'b1);
        send_bits(8'h01, 1);
        snap(8'h4A, 1'b0, 1'b1);
        rd_en = 1'b0;
        wait_clk(2);

        // Start condition inside a byte
        is_byte = 1'b1;
        rd_en = 1'b1;
        send_bits(8'h03, 2);
        sda = 1'b1;
        wait_clk(2);
        scl = 1'b1;
        wait_clk(4);
        push_ev(KSTART);
        sda = 1'b0;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(2);
        snap(8'h57, 1'b1, 1'b0);
        send_bits(8'h00, 8);
        snap(8'h00, 1'b1, 1'b0);
        rd_en = 1'b0;
        wait_clk(2);

        // Stop before the first rise (rd_en raised with SCL high)
        sda = 1'b0;
        wait_clk(2);
        scl = 1'b1;
        wait_clk(2);
        rd_en = 1'b1;
        wait_clk(2);
        push_ev(KSTOP);
        sda = 1'b1;
        wait_clk(2);
        snap(8'h00, 1'b0, 1'b0);
        scl = 1'b0;
        wait_clk(2);
        send_bits(8'hFF, 8);
        snap(8'hFF, 1'b0, 1'b0);
        rd_en = 1'b0;
        wait_clk(2);

        // rd_en dropped after 5 bits, then clean 0x3C
        rd_en = 1'b1;
        send_bits(8'h16, 5);
        snap(8'hF6, 1'b0, 1'b0);
        rd_en = 1'b0;
        wait_clk(2);
        snap(8'hF6, 1'b0, 1'b0);
        rd_en = 1'b1;
        push_fin(8'h3C, 8);
        send_bits(8'h3C, 8);
        snap(8'h3C, 1'b0, 1'b1);
        rd_en = 1'b0;
        wait_clk(2);

        // Async reset during bit 6, then a clean 0xC3
        rd_en = 1'b1;
        send_bits(8'h1F, 5);
        sda = 1'b1;
        wait_clk(2);
        scl = 1'b1;
        wait_clk(2);
        rst_n = 1'b0;
        rd_en = 1'b0;
        scl = 1'b0;
        snap(8'h00, 1'b0, 1'b0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        rd_en = 1'b1;
        push_fin(8'hC3, 8);
        send_bits(8'hC3, 8);
        snap(8'hC3, 1'b0, 1'b1);
        rd_en = 1'b0;
        wait_clk(4);

        check("pending_expectations", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
